add8u_err_monitor: RTL and testbench



---
 rtl/add8u_eval_pkg.sv | 30 +++
 rtl/add8u_err_stage.sv | 26 ++
 rtl/add8u_err_monitor.sv | 154 +++++++++++++++
 tb/tb_add8u_err_monitor.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/add8u_eval_pkg.sv
// Shared types and helpers for the add8u error-metric monitor.
// Holds the FSM encoding, default widths and saturating accumulation.
package add8u_eval_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    REPORT
  } state_t;

  localparam int WIDTH_D = 8;
  localparam int CNT_W_D = 17;
  localparam int ABS_W_D = 27;
  localparam int SQ_W_D  = 36;

  // Clamp to the all-ones value of a w-bit register instead of wrapping
  function automatic logic [63:0] sat_add(
    input logic [63:0] acc,
    input logic [63:0] inc,
    input int          w
  );
    logic [64:0] sum;
    logic [64:0] lim;
    sum = {1'b0, acc} + {1'b0, inc};
    lim = (65'd1 << w) - 65'd1;
    return (sum > lim) ? lim[63:0] : sum[63:0];
  endfunction

endpackage

// File: rtl/add8u_err_stage.sv
// Combinational error arithmetic for the monitor pipeline.
// Front half feeds S1 (|O - (A+B)|), back half feeds S2 (square).
module add8u_err_stage #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH:0]     o,
  input  logic [WIDTH:0]     mag,
  output logic [WIDTH:0]     abs_err,
  output logic [2*WIDTH+1:0] sq
);

  logic [WIDTH:0] exact;

  always_comb begin
    exact = {1'b0, a} + {1'b0, b};
    if (o >= exact) begin
      abs_err = o - exact;
    end else begin
      abs_err = exact - o;
    end
    sq = (2*WIDTH+2)'(mag) * (2*WIDTH+2)'(mag);
  end

endmodule

// File: rtl/add8u_err_monitor.sv
// Streaming MAE/MSE/WCE/EP accumulator for approximate 8-bit adders.
// Two-stage error pipeline feeding saturating accumulators under an FSM.
module add8u_err_monitor
  import add8u_eval_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int CNT_W = CNT_W_D,
  parameter int ABS_W = ABS_W_D,
  parameter int SQ_W  = SQ_W_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH:0]   in_o,
  input  logic             in_last,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_count,
  output logic [ABS_W-1:0] res_sum_abs,
  output logic [SQ_W-1:0]  res_sum_sq,
  output logic [WIDTH:0]   res_wce,
  output logic [CNT_W-1:0] res_err_cnt,
  output logic             busy
);

  state_t state;
  state_t state_n;
  logic   flush;
  logic   accept;

  logic                 s1_valid;
  logic [WIDTH:0]       s1_abs;
  logic                 s2_valid;
  logic [WIDTH:0]       s2_abs;
  logic [2*WIDTH+1:0]   s2_sq;

  logic [WIDTH:0]       abs_err;
  logic [2*WIDTH+1:0]   sq;

  logic [CNT_W-1:0] count;
  logic [ABS_W-1:0] sum_abs;
  logic [SQ_W-1:0]  sum_sq;
  logic [WIDTH:0]   wce;
  logic [CNT_W-1:0] err_cnt;

  add8u_err_stage #(
    .WIDTH(WIDTH)
  ) u_stage (
    .a      (in_a),
    .b      (in_b),
    .o      (in_o),
    .mag    (s1_abs),
    .abs_err(abs_err),
    .sq     (sq)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b0;
    flush     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          flush   = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (start) begin
          flush = 1'b1;
        end else if (in_valid && in_last) begin
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (start) begin
          flush   = 1'b1;
          state_n = RUN;
        end else if (!s1_valid) begin
          // S2 retires on this edge, so the pipeline is empty in REPORT
          state_n = REPORT;
        end
      end
      REPORT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign accept = in_valid && in_ready && !start;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      s1_valid <= 1'b0;
      s1_abs   <= '0;
      s2_valid <= 1'b0;
      s2_abs   <= '0;
      s2_sq    <= '0;
      count    <= '0;
      sum_abs  <= '0;
      sum_sq   <= '0;
      wce      <= '0;
      err_cnt  <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_abs <= abs_err;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_abs <= s1_abs;
        s2_sq  <= sq;
      end
      if (s2_valid) begin
        count   <= CNT_W'(sat_add(64'(count), 64'd1, CNT_W));
        sum_abs <= ABS_W'(sat_add(64'(sum_abs), 64'(s2_abs), ABS_W));
        sum_sq  <= SQ_W'(sat_add(64'(sum_sq), 64'(s2_sq), SQ_W));
        err_cnt <= CNT_W'(sat_add(64'(err_cnt),
                                  64'(s2_abs != '0), CNT_W));
        if (s2_abs > wce) begin
          wce <= s2_abs;
        end
      end
    end
  end

  assign res_count   = count;
  assign res_sum_abs = sum_abs;
  assign res_sum_sq  = sum_sq;
  assign res_wce     = wce;
  assign res_err_cnt = err_cnt;

endmodule

// File: tb/tb_add8u_err_monitor.sv
// Scoreboard bench for add8u_err_monitor: a software model predicts
// each run's statistics, which are queued and compared at REPORT.
module tb_add8u_err_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [8:0]  in_o;
  logic        in_last;
  logic        res_ready;

  logic        in_ready;
  logic        res_valid;
  logic [16:0] res_count;
  logic [26:0] res_sum_abs;
  logic [35:0] res_sum_sq;
  logic [8:0]  res_wce;
  logic [16:0] res_err_cnt;
  logic        busy;

  logic        s_in_ready;
  logic        s_res_valid;
  logic [3:0]  s_res_count;
  logic [26:0] s_res_sum_abs;
  logic [35:0] s_res_sum_sq;
  logic [8:0]  s_res_wce;
  logic [3:0]  s_res_err_cnt;
  logic        s_busy;

  typedef struct {
    longint cnt;
    longint sabs;
    longint ssq;
    longint wce;
    longint ecnt;
  } res_t;

  res_t   exp_q[$];
  res_t   m;
  int     n_checks = 0;
  int     n_errors = 0;

  always #5 clk = ~clk;

  add8u_err_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_o       (in_o),
    .in_last    (in_last),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_count  (res_count),
    .res_sum_abs(res_sum_abs),
    .res_sum_sq (res_sum_sq),
    .res_wce    (res_wce),
    .res_err_cnt(res_err_cnt),
    .busy       (busy)
  );

  add8u_err_monitor #(
    .CNT_W(4)
  ) dut_sat (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (s_in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_o       (in_o),
    .in_last    (in_last),
    .res_valid  (s_res_valid),
    .res_ready  (res_ready),
    .res_count  (s_res_count),
    .res_sum_abs(s_res_sum_abs),
    .res_sum_sq (s_res_sum_sq),
    .res_wce    (s_res_wce),
    .res_err_cnt(s_res_err_cnt),
    .busy       (s_busy)
  );

  task automatic check(input string tag, input longint got,
                       input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    m = '{default: 0};
  endtask

  task automatic send(input int a, input int b, input int o,
                      input bit last);
    int e;
    in_valid = 1'b1;
    in_a     = 8'(a);
    in_b     = 8'(b);
    in_o     = 9'(o);
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    e = o - (a + b);
    if (e < 0) e = -e;
    m.cnt++;
    m.sabs += e;
    m.ssq  += longint'(e) * e;
    if (e > m.wce) m.wce = e;
    if (e != 0) m.ecnt++;
    if (last) exp_q.push_back(m);
  endtask

  task automatic wait_report(input string tag);
    int k;
    k = 0;
    while (!res_valid && k < 20) begin
      tick();
      k++;
    end
    check({tag, "_res_valid"}, longint'(res_valid), 1);
  endtask

  task automatic compare(input string tag);
    res_t e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 0, 1);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_count"}, longint'(res_count), e.cnt);
    check({tag, "_sum_abs"}, longint'(res_sum_abs), e.sabs);
    check({tag, "_sum_sq"}, longint'(res_sum_sq), e.ssq);
    check({tag, "_wce"}, longint'(res_wce), e.wce);
    check({tag, "_err_cnt"}, longint'(res_err_cnt), e.ecnt);
  endtask

  task automatic consume(input string tag);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, "_idle_valid"}, longint'(res_valid), 0);
    check({tag, "_idle_busy"}, longint'(busy), 0);
  endtask

  initial begin
    int ov;
    int ex;
    rst       = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_o      = '0;
    in_last   = 1'b0;
    res_ready = 1'b0;
    m         = '{default: 0};
    repeat (3) tick();
    check("rst_in_ready", longint'(in_ready), 0);
    check("rst_res_valid", longint'(res_valid), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_count", longint'(res_count), 0);
    check("rst_sum_sq", longint'(res_sum_sq), 0);
    rst = 1'b0;
    tick();

    // exact stream
    do_start();
    check("run_busy", longint'(busy), 1);
    check("run_in_ready", longint'(in_ready), 1);
    send(1, 2, 3, 0);
    send(255, 255, 510, 0);
    send(0, 0, 0, 0);
    send(128, 127, 255, 1);
    check("drain_in_ready", longint'(in_ready), 0);
    wait_report("exact");
    compare("exact");
    consume("exact");

    // known errors plus backpressure in REPORT
    do_start();
    send(0, 7, 0, 0);
    send(10, 10, 28, 0);
    send(5, 5, 10, 1);
    wait_report("known");
    for (int i = 0; i < 10; i++) begin
      start    = (i == 4);
      in_valid = (i == 4);
      tick();
      start    = 1'b0;
      in_valid = 1'b0;
      check("bp_res_valid", longint'(res_valid), 1);
      check("bp_in_ready", longint'(in_ready), 0);
      check("bp_sum_abs", longint'(res_sum_abs), 15);
    end
    check("known_fixed_sum_sq", longint'(res_sum_sq), 113);
    check("known_fixed_wce", longint'(res_wce), 8);
    compare("known");
    consume("known");

    // saturation on the narrow-counter instance
    do_start();
    for (int i = 0; i < 20; i++) send(0, 0, 1, i == 19);
    wait_report("sat");
    check("sat_count", longint'(s_res_count), 15);
    check("sat_err_cnt", longint'(s_res_err_cnt), 15);
    check("sat_sum_abs", longint'(s_res_sum_abs), 20);
    check("sat_res_valid", longint'(s_res_valid), 1);
    compare("sat_wide");
    consume("sat");

    // reset mid-run discards everything
    do_start();
    for (int i = 0; i < 5; i++) send(i, i, 2 * i + 3, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_count", longint'(res_count), 0);
    check("mid_rst_sum_abs", longint'(res_sum_abs), 0);
    check("mid_rst_sum_sq", longint'(res_sum_sq), 0);
    check("mid_rst_wce", longint'(res_wce), 0);
    check("mid_rst_err_cnt", longint'(res_err_cnt), 0);
    check("mid_rst_in_ready", longint'(in_ready), 0);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (res_valid) seen = 1'b1;
      end
      check("mid_rst_no_report", longint'(seen), 0);
    end

    // exhaustive sweep with low nibble replaced by OR of operands
    do_start();
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        ex = a + b;
        ov = (ex & 'h1f0) | ((a | b) & 'hf);
        send(a, b, ov, (a == 255) && (b == 255));
      end
    end
    wait_report("exh");
    compare("exh");
    consume("exh");

    check("queue_empty", longint'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
